// File: rtl/pmp_chk_arb.sv
// Shares one pmp_compare among REQ_NUM requesters with round-robin grant.
// The checker re-runs when PMP CSRs change, captures the first denial and counts denials.
module pmp_chk_arb #(
    parameter int  REQ_NUM    = 3,
    parameter int  ADDR_WIDTH = 32,
    parameter int  ID_WIDTH   = 4,
    parameter int  CNT_WIDTH  = 16,
    localparam int SRC_W      = $clog2(REQ_NUM)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [REQ_NUM-1:0]                 v_req_vld,
    output logic [REQ_NUM-1:0]                 v_req_rdy,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] v_req_addr,
    input  logic [REQ_NUM-1:0][1:0]            v_req_mode,
    input  logic [REQ_NUM-1:0][ID_WIDTH-1:0]   v_req_id,
    output logic [ADDR_WIDTH-1:0]              chk_addr,
    output logic [1:0]                         chk_mode,
    input  logic                               chk_pass,
    input  logic                               cfg_update,
    output logic                               rsp_vld,
    input  logic                               rsp_rdy,
    output logic                               rsp_pass,
    output logic [ID_WIDTH-1:0]                rsp_id,
    output logic [SRC_W-1:0]                   rsp_src,
    output logic                               fault_vld,
    output logic [ADDR_WIDTH-1:0]              fault_addr,
    output logic [1:0]                         fault_mode,
    output logic [SRC_W-1:0]                   fault_src,
    input  logic                               fault_clr,
    output logic [CNT_WIDTH-1:0]               deny_cnt
);
    typedef enum logic [1:0] {IDLE, CHK, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            mode;
        logic [ID_WIDTH-1:0]   id;
        logic [SRC_W-1:0]      src;
    } hold_t;

    state_t           state;
    hold_t            hold;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_src;
    logic             gnt_any;
    logic             gnt_fire;
    logic             rsp_hs;
    logic             deny_hs;

    // rsp_vld is high for the whole RESP state, so the handshake needs only rsp_rdy
    assign rsp_hs   = (state == RESP) && rsp_rdy;
    assign deny_hs  = rsp_hs && !rsp_pass;
    assign gnt_fire = rst_n && gnt_any && ((state == IDLE) || rsp_hs);

    // First valid requester at or above rr_ptr, otherwise first valid below it
    always_comb begin
        gnt_any = 1'b0;
        gnt_src = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!gnt_any && v_req_vld[i] && (SRC_W'(i) >= rr_ptr)) begin
                gnt_any = 1'b1;
                gnt_src = SRC_W'(i);
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!gnt_any && v_req_vld[i]) begin
                gnt_any = 1'b1;
                gnt_src = SRC_W'(i);
            end
        end
    end

    always_comb begin
        v_req_rdy = '0;
        for (int i = 0; i < REQ_NUM; i++)
            v_req_rdy[i] = gnt_fire && (gnt_src == SRC_W'(i));
    end

    assign chk_addr = hold.addr;
    assign chk_mode = hold.mode;
    assign rsp_id   = hold.id;
    assign rsp_src  = hold.src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            rr_ptr     <= '0;
            rsp_vld    <= 1'b0;
            rsp_pass   <= 1'b0;
            fault_vld  <= 1'b0;
            fault_addr <= '0;
            fault_mode <= '0;
            fault_src  <= '0;
            deny_cnt   <= '0;
        end else begin
            if (gnt_fire) begin
                hold   <= {v_req_addr[gnt_src], v_req_mode[gnt_src], v_req_id[gnt_src], gnt_src};
                rr_ptr <= (gnt_src == SRC_W'(REQ_NUM - 1)) ? '0 : gnt_src + 1'b1;
            end

            case (state)
                IDLE: if (gnt_fire) state <= CHK;
                // A CSR write during the check invalidates the sample; look again next cycle
                CHK: if (!cfg_update) begin
                    rsp_pass <= chk_pass && (hold.mode != 2'b00);
                    rsp_vld  <= 1'b1;
                    state    <= RESP;
                end
                RESP: if (rsp_rdy) begin
                    rsp_vld <= 1'b0;
                    state   <= gnt_fire ? CHK : IDLE;
                end else if (cfg_update) begin
                    rsp_vld <= 1'b0;
                    state   <= CHK;
                end
                default: state <= IDLE;
            endcase

            if (deny_hs && (!fault_vld || fault_clr)) begin
                fault_vld  <= 1'b1;
                fault_addr <= hold.addr;
                fault_mode <= hold.mode;
                fault_src  <= hold.src;
            end else if (fault_clr) begin
                fault_vld <= 1'b0;
            end

            if (deny_hs && (deny_cnt != '1))
                deny_cnt <= deny_cnt + 1'b1;
        end
    end

    // Requesters must hold their request stable until accepted
    for (genvar g = 0; g < REQ_NUM; g++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (v_req_vld[g] && !v_req_rdy[g]) |=> (v_req_vld[g] && $stable(v_req_addr[g])
                && $stable(v_req_mode[g]) && $stable(v_req_id[g])));
    end

endmodule

// File: tb/tb_pmp_chk_arb.sv
// Random and directed traffic into pmp_chk_arb; a negedge monitor scores every output
// against a transaction-level model (grant order, response timing, fault capture, denial count).
module tb_pmp_chk_arb;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int CW = 8;
    localparam int SW = 2;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic [N-1:0]        v_req_vld  = '0;
    logic [N-1:0]        v_req_rdy;
    logic [N-1:0][AW-1:0] v_req_addr = '0;
    logic [N-1:0][1:0]   v_req_mode = '0;
    logic [N-1:0][IW-1:0] v_req_id  = '0;
    logic [AW-1:0]       chk_addr;
    logic [1:0]          chk_mode;
    logic                chk_pass;
    logic                cfg_update = 1'b0;
    logic                rsp_vld;
    logic                rsp_rdy    = 1'b1;
    logic                rsp_pass;
    logic [IW-1:0]       rsp_id;
    logic [SW-1:0]       rsp_src;
    logic                fault_vld;
    logic [AW-1:0]       fault_addr;
    logic [1:0]          fault_mode;
    logic [SW-1:0]       fault_src;
    logic                fault_clr  = 1'b0;
    logic [CW-1:0]       deny_cnt;

    // PMP policy: one permission bit per 4 KiB region; fetches also need addr[16] clear
    logic [15:0] pol     = 16'hffff;
    logic [15:0] pol_old = 16'hffff;

    function automatic logic perm(input logic [AW-1:0] a, input logic [1:0] m, input logic [15:0] p);
        return p[a[15:12]] && !(m == 2'b11 && a[16]);
    endfunction

    assign chk_pass = perm(chk_addr, chk_mode, pol);

    pmp_chk_arb #(.REQ_NUM(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .v_req_vld(v_req_vld), .v_req_rdy(v_req_rdy), .v_req_addr(v_req_addr),
        .v_req_mode(v_req_mode), .v_req_id(v_req_id),
        .chk_addr(chk_addr), .chk_mode(chk_mode), .chk_pass(chk_pass), .cfg_update(cfg_update),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_pass(rsp_pass), .rsp_id(rsp_id), .rsp_src(rsp_src),
        .fault_vld(fault_vld), .fault_addr(fault_addr), .fault_mode(fault_mode), .fault_src(fault_src),
        .fault_clr(fault_clr), .deny_cnt(deny_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- monitor / scoreboard (owns all counters and model state) ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    mode;
        logic [IW-1:0] id;
        int            src;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;
    int            ready_at   = 0;
    int            rr_m       = 0;
    int            winner;
    int            gnt_cnt[N] = '{default: 0};
    bit            busy       = 1'b0;
    bit            rst_seen   = 1'b0;
    bit            exp_vld, hs, exp_any, p;
    logic [N-1:0]  onehot;
    logic          fv_m = 1'b0;
    logic [AW-1:0] fa_m = '0;
    logic [1:0]    fm_m = '0;
    logic [SW-1:0] fs_m = '0;
    logic [CW-1:0] deny_m = '0;

    // written only by the stimulus process
    int seen_cnt[N] = '{default: 0};
    int tmo_cnt     = 0;
    bit done        = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            chk("stim_timeouts", 64'(tmo_cnt), 0);
            chk("final_queue_empty", 64'(q.size()), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end else if (!rst_n) begin
            if (rst_seen) begin
                chk("rst_rsp_vld", rsp_vld, 0);
                chk("rst_rsp_fields", {rsp_pass, rsp_id, rsp_src}, 0);
                chk("rst_chk", {chk_addr, chk_mode}, 0);
                chk("rst_fault", {fault_vld, fault_addr, fault_mode, fault_src}, 0);
                chk("rst_deny_cnt", deny_cnt, 0);
                chk("rst_rdy", v_req_rdy, 0);
            end
            rst_seen = 1'b1;
            q.delete();
            busy = 1'b0; rr_m = 0; ready_at = 0;
            fv_m = 1'b0; fa_m = '0; fm_m = '0; fs_m = '0; deny_m = '0;
        end else begin
            rst_seen = 1'b0;
            // response is on offer from ready_at until handshake
            exp_vld = busy && (cyc >= ready_at);
            hs      = exp_vld && rsp_rdy;
            p       = 1'b0;
            chk("rsp_vld", rsp_vld, exp_vld);
            if (exp_vld) begin
                e = q[0];
                // a CSR write landing this cycle cannot affect the result already on offer
                p = (e.mode != 2'b00) && perm(e.addr, e.mode, cfg_update ? pol_old : pol);
                chk("rsp_pass", rsp_pass, p);
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_src", rsp_src, 64'(e.src));
            end
            if (busy) begin
                chk("chk_addr", chk_addr, q[0].addr);
                chk("chk_mode", chk_mode, q[0].mode);
            end
            chk("fault_vld", fault_vld, fv_m);
            chk("fault_data", {fault_addr, fault_mode, fault_src}, {fa_m, fm_m, fs_m});
            chk("deny_cnt", deny_cnt, deny_m);

            exp_any = (|v_req_vld) && (!busy || hs);
            chk("grant_any", |v_req_rdy, exp_any);
            chk("grant_onehot", 64'($countones(v_req_rdy) <= 1), 1);
            winner = -1;
            for (int k = N - 1; k >= 0; k--)
                if (v_req_vld[(rr_m + k) % N]) winner = (rr_m + k) % N;
            if (exp_any) begin
                onehot = '0;
                onehot[winner] = 1'b1;
                chk("grant_sel", v_req_rdy, onehot);
            end
            for (int i = 0; i < N; i++)
                if (v_req_rdy[i]) gnt_cnt[i]++;

            if (hs && !p) begin
                if (deny_m != '1) deny_m++;
            end
            if (hs && !p && (!fv_m || fault_clr)) begin
                fv_m = 1'b1; fa_m = e.addr; fm_m = e.mode; fs_m = SW'(e.src);
            end else if (fault_clr) begin
                fv_m = 1'b0;
            end
            if (hs) begin
                void'(q.pop_front());
                busy = 1'b0;
            end
            if (busy && cfg_update) ready_at = cyc + 2;
            if (exp_any) begin
                e.addr = v_req_addr[winner];
                e.mode = v_req_mode[winner];
                e.id   = v_req_id[winner];
                e.src  = winner;
                q.push_back(e);
                busy     = 1'b1;
                ready_at = cyc + 2;
                rr_m     = (winner + 1) % N;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cfg_update = 1'b0;
        fault_clr  = 1'b0;
        for (int i = 0; i < N; i++)
            if (gnt_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i]  = gnt_cnt[i];
                v_req_vld[i] = 1'b0;
            end
    endtask

    task automatic set_pol(input logic [15:0] np);
        pol_old    = pol;
        pol        = np;
        cfg_update = 1'b1;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [1:0] m, input logic [IW-1:0] id);
        for (int n = 0; n < 100 && v_req_vld[i]; n++) step();
        if (v_req_vld[i]) tmo_cnt++;
        else begin
            v_req_addr[i] = a;
            v_req_mode[i] = m;
            v_req_id[i]   = id;
            v_req_vld[i]  = 1'b1;
        end
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 50 && !rsp_vld; n++) step();
        if (!rsp_vld) tmo_cnt++;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && (|v_req_vld); n++) step();
        if (|v_req_vld) tmo_cnt++;
        repeat (6) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic rand_run(input int cycles, input int p_req, input int p_rdy,
                            input int p_cfg, input int p_clr, input bit new_pol);
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < N; i++)
                if (!v_req_vld[i] && int'($urandom_range(99)) < p_req) begin
                    v_req_addr[i] = $urandom();
                    v_req_mode[i] = 2'($urandom_range(3));
                    v_req_id[i]   = IW'($urandom());
                    v_req_vld[i]  = 1'b1;
                end
            rsp_rdy = (int'($urandom_range(99)) < p_rdy);
            if (int'($urandom_range(99)) < p_cfg) set_pol(new_pol ? 16'($urandom()) : pol);
            fault_clr = (int'($urandom_range(99)) < p_clr);
        end
        rsp_rdy = 1'b1;
        wait_idle();
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;

        // single permitted load
        issue(0, 32'h8000_0000, 2'b01, 4'd3);
        wait_idle();

        // all requesters continuously valid: rotation 0,1,2,0...
        rand_run(40, 100, 100, 0, 0, 1'b0);

        // backpressure, then a CSR write revokes permission while the response waits
        rsp_rdy = 1'b0;
        issue(1, 32'h0000_3000, 2'b10, 4'd7);
        wait_rsp();
        set_pol(16'h0000);
        repeat (3) step();
        rsp_rdy = 1'b1;
        wait_idle();

        // first-fault capture, then replacement with a coincident fault_clr
        do_reset();
        issue(1, 32'h0000_1000, 2'b10, 4'd1);
        wait_idle();
        issue(2, 32'h0000_2000, 2'b01, 4'd2);
        wait_idle();
        rsp_rdy = 1'b0;
        issue(2, 32'h0000_2000, 2'b10, 4'd4);
        wait_rsp();
        rsp_rdy   = 1'b1;
        fault_clr = 1'b1;
        step();
        wait_idle();
        fault_clr = 1'b1;
        step();
        step();

        // illegal mode 00 is denied even though the region allows it
        set_pol(16'hffff);
        step();
        issue(0, 32'h0000_5000, 2'b00, 4'd9);
        wait_idle();

        // counter saturation: everything denied, well over 2^CW denials
        set_pol(16'h0000);
        step();
        rand_run(800, 100, 100, 0, 0, 1'b0);

        // reset while a response is waiting
        set_pol(16'hffff);
        step();
        rsp_rdy = 1'b0;
        issue(0, 32'h0000_7000, 2'b01, 4'd5);
        wait_rsp();
        do_reset();
        rsp_rdy = 1'b1;
        step();

        // mixed random traffic with CSR writes, backpressure and fault clears
        rand_run(3000, 40, 60, 5, 5, 1'b1);

        done = 1'b1;
        forever step();
    end

endmodule

// File: doc/pmp_chk_arb.md
Name: pmp_chk_arb

Overview:
Arbitrates a single shared pmp_compare instance among REQ_NUM requesters (fetch, load, store ports of the scalar core). Each request is sequenced through a one-cycle check and a held response, and re-checked when the PMP CSRs are rewritten mid-flight. Captures the first denied access (address, mode, source) for the trap unit and keeps a saturating count of denials. Sits between the core LSU/IFU request channels and the pmp_compare datapath.

Parameters:
REQ_NUM, 3, number of requesters sharing the checker (>=2)
ADDR_WIDTH, 32, physical address width
ID_WIDTH, 4, transaction tag width returned with the response
CNT_WIDTH, 16, width of the denial counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
v_req_vld  in  REQ_NUM  per-requester request valid
v_req_rdy  out  REQ_NUM  per-requester accept (one-hot grant)
v_req_addr  in  REQ_NUM x ADDR_WIDTH  request address
v_req_mode  in  REQ_NUM x 2  01 load, 10 store, 11 fetch, 00 illegal
v_req_id  in  REQ_NUM x ID_WIDTH  request tag
chk_addr  out  ADDR_WIDTH  address to shared pmp_compare
chk_mode  out  2  mode to shared pmp_compare
chk_pass  in  1  combinational pass result from pmp_compare
cfg_update  in  1  pulse: a pmpcfg/pmpaddr CSR was written this cycle
rsp_vld  out  1  response valid
rsp_rdy  in  1  response accept
rsp_pass  out  1  1 = access permitted
rsp_id  out  ID_WIDTH  tag of the responded request
rsp_src  out  $clog2(REQ_NUM)  requester index of the response
fault_vld  out  1  sticky: a denial is captured
fault_addr  out  ADDR_WIDTH  captured denied address
fault_mode  out  2  captured denied mode
fault_src  out  $clog2(REQ_NUM)  captured requester index
fault_clr  in  1  clears fault_vld
deny_cnt  out  CNT_WIDTH  saturating count of denied responses

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, rr pointer 0, v_req_rdy=0, rsp_vld=0, rsp_pass=0, rsp_id=0, rsp_src=0, chk_addr=0, chk_mode=0, fault_vld=0, fault_addr=0, fault_mode=0, fault_src=0, deny_cnt=0. Reset mid-operation drops the in-flight request with no response.
- States: IDLE, CHK, RESP.
- Grant: a combinational round-robin starting at the rr pointer, asserted only in IDLE, or in RESP in the cycle rsp_vld&rsp_rdy. v_req_rdy[i]=grant[i]; at most one bit is set. On grant, latch addr/mode/id/src into the holding register, set rr pointer=(src+1) mod REQ_NUM, go CHK.
- Requesters hold vld/addr/mode/id stable until rdy. Dropping vld before rdy is illegal and is checked by assertion.
- chk_addr/chk_mode are driven from the holding register (registered outputs, stable in CHK and RESP).
- CHK: sample pass_r = chk_pass & (mode!=00), then go RESP. If cfg_update=1 in CHK, discard the sample and stay in CHK one more cycle.
- RESP: rsp_vld=1; pass/id/src are stable until the handshake.
  - Handshake: go CHK if a new grant occurs, else IDLE.
  - cfg_update=1 without handshake: rsp_vld drops next cycle, go CHK (re-check).
  - cfg_update=1 together with a handshake: the handshake completes with the old result.
- Latency: grant at cycle T, rsp_vld at T+2 (absent cfg_update). Peak throughput is one response per 2 cycles.
- Fault capture: on a handshake with rsp_pass=0, if fault_vld=0 or fault_clr=1 the same cycle, load fault_addr/mode/src and set fault_vld=1. Otherwise the old capture is kept. fault_clr without a new fault clears fault_vld only; the data fields hold.
- deny_cnt increments on each denied handshake and saturates at all-ones. It is cleared only by reset.
- Illegal mode 00 always yields rsp_pass=0, independent of chk_pass.

Test Plan:
- Single load: req0 vld addr=0x8000_0000 mode=01 id=3, chk_pass=1, rsp_rdy=1 -> rdy0 at T, rsp_vld at T+2 with pass=1, id=3, src=0; fault_vld stays 0.
- Round-robin: all 3 vld continuously, rsp_rdy=1 -> grants 0,1,2,0 on cycles T, T+2, T+4, T+6; no starvation.
- Backpressure + cfg_update: rsp_rdy=0 in RESP, pulse cfg_update, chk_pass flips 1->0 -> rsp_vld low 1 cycle, re-asserts with pass=0; deny_cnt=1.
- Fault capture: denial on src1 addr=0x1000 mode=10, then denial on src2 addr=0x2000 -> fault_addr=0x1000, src=1. fault_clr coincident with the src2 denial -> fault_addr=0x2000, src=2.
- Illegal mode 00 with chk_pass=1 -> rsp_pass=0, fault captured, deny_cnt increments.
- Saturation/reset: 65536 denials -> deny_cnt=0xFFFF holds. rst_n=0 during RESP -> next cycle rsp_vld=0, state IDLE, all outputs at reset values.
